// File: rtl/md_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// Define MD_UNIT_SIGNED_EN to make op 01 (MULT) and op 11 (DIV) signed; otherwise they run unsigned.
module md_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

`ifdef MD_UNIT_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] a_q;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [4:0]  cnt;

    // Handshake: start is accepted only in IDLE or DONE; while busy it and the
    // direct writes are dropped, with no queuing.
    logic        accept;
    logic        sgn_in;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign sgn_in   = op[0] & SIGNED_EN;
    assign neg_a_in = sgn_in & src_a[31];
    assign neg_b_in = sgn_in & src_b[31];
    assign mag_a_in = neg_a_in ? (32'd0 - src_a) : src_a;
    assign mag_b_in = neg_b_in ? (32'd0 - src_b) : src_b;

    assign busy      = (state == CALC) || (state == FIX);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // One iteration step: acc_hi is the partial product / running remainder,
    // acc_lo holds the multiplier or dividend bits and collects the quotient.
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [32:0] div_diff;
    logic        div_ok;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : 33'd0);
    assign div_trial = {acc_hi, acc_lo[31]};
    assign div_diff  = div_trial - {1'b0, mag_b};
    assign div_ok    = ~div_diff[32];

    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        prod   = {acc_hi, acc_lo};
        if (!is_div) begin
            if (neg_a ^ neg_b) begin
                prod = 64'd0 - prod;
            end
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (mag_b == 32'd0) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_lo = (neg_a ^ neg_b) ? (32'd0 - acc_lo) : acc_lo;
            res_hi = neg_a ? (32'd0 - acc_hi) : acc_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (cnt == 5'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_q    <= 32'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            cnt    <= 5'd0;
        end else begin
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (!busy) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
            end

            if (accept) begin
                is_div <= op[1];
                neg_a  <= neg_a_in;
                neg_b  <= neg_b_in;
                a_q    <= src_a;
                mag_a  <= mag_a_in;
                mag_b  <= mag_b_in;
                acc_hi <= 32'd0;
                acc_lo <= op[1] ? mag_a_in : mag_b_in;
                cnt    <= 5'd0;
            end else if (state == CALC) begin
                cnt <= cnt + 5'd1;
                if (!is_div) begin
                    acc_hi <= mul_sum[32:1];
                    acc_lo <= {mul_sum[0], acc_lo[31:1]};
                end else begin
                    // Restoring step: keep the difference only when it did not go negative.
                    acc_hi <= div_ok ? div_diff[31:0] : div_trial[31:0];
                    acc_lo <= {acc_lo[30:0], div_ok};
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected {hi,lo} pairs are queued at issue time and a
// monitor pops and compares them on every done pulse; timing and reset are checked inline.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    md_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done with hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                check("hi_lo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the start edge; done must rise after the 33rd following edge.
    task automatic track(input string name, input int inject_at);
        int k;
        int busy_cnt;
        bit inj;
        busy_cnt = busy ? 1 : 0;
        inj = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (inj) begin
                start = 1'b0;
                wr_hi = 1'b0;
                inj   = 1'b0;
                check({name, "_ignored_wr_hi"}, {32'd0, hi}, {32'd0, 32'h0000_1234});
            end
            if (done) break;
            if (busy) busy_cnt++;
            if (k == inject_at) begin
                @(negedge clk);
                start   = 1'b1;
                op      = 2'b10;
                src_a   = 32'd9;
                src_b   = 32'd3;
                wr_hi   = 1'b1;
                wr_data = 32'h55;
                inj     = 1'b1;
            end
        end
        check({name, "_latency"}, k, 33);
        check({name, "_busy_cycles"}, busy_cnt, 33);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        src_a   = 32'd0;
        src_b   = 32'd0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;

        issue(2'b00, 32'd7, 32'd6, {32'd0, 32'd42}, 1);
        track("multu_7x6", -1);

`ifdef MD_UNIT_SIGNED_EN
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1);
        track("mult_neg3x5", -1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
        track("div_neg7_2", -1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1);
        track("div_min_neg1", -1);
        issue(2'b11, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1);
        track("div_7_neg2", -1);
`else
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, {32'h0000_0004, 32'hFFFF_FFF1}, 1);
        track("mult_neg3x5", -1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 1);
        track("div_neg7_2", -1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1);
        track("div_min_neg1", -1);
        issue(2'b11, 32'd7, 32'hFFFF_FFFE, {32'h0000_0007, 32'h0000_0000}, 1);
        track("div_7_neg2", -1);
`endif

        issue(2'b10, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1);
        track("divu_by_zero", -1);
        issue(2'b11, 32'hFFFF_FF9C, 32'd0, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 1);
        track("div_by_zero", -1);
        issue(2'b10, 32'd1000, 32'd7, {32'd6, 32'd142}, 1);
        track("divu_1000_7", -1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1);
        track("multu_max", -1);

        // reset in the middle of a divide
        issue(2'b10, 32'd1000, 32'd7, 64'd0, 0);
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        issue(2'b00, 32'd3, 32'd3, {32'd0, 32'd9}, 1);
        track("multu_3x3_after_rst", -1);

        // back-to-back issue from DONE
        issue(2'b00, 32'h0001_0000, 32'h0001_0000, {32'd1, 32'd0}, 1);
        track("b2b_first", -1);
        issue(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
        check("b2b_no_idle_busy", busy, 1);
        track("b2b_second", -1);

        // direct writes while idle, then ignored start and write while busy
        @(negedge clk);
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
        wr_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("direct_wr_hi", hi, 32'h0000_1234);
        check("direct_wr_lo", lo, 32'h0000_1234);
        issue(2'b00, 32'd12345, 32'd100, {32'd0, 32'h0012_D644}, 1);
        track("multu_ignore", 10);

        // write accepted on the same edge as start, later overwritten by the result
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        src_a   = 32'd2;
        src_b   = 32'd3;
        wr_lo   = 1'b1;
        wr_data = 32'h0000_00AA;
        exp_q.push_back({32'd0, 32'd6});
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_lo = 1'b0;
        check("start_wr_lo", lo, 32'h0000_00AA);
        track("multu_with_wr", -1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("final_idle", state_dbg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
